// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: accepts one encode request at a time and
// writes the encoded word into instruction memory one cycle after acceptance.
module instr_encoder (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] target_i,
    input  logic        err_clr_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [31:0] pc_o,
    output logic [15:0] count_o,
    output logic        err_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic [15:0]        count;
    logic               err;
    logic [31:0]        mem_addr_p1;
    logic [31:0]        mem_data_p1;
    logic               accept;
    logic               legal_p0;
    logic [31:0]        instr_p0;
    logic signed [31:0] br_diff;
    logic signed [31:0] br_off;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic fits_s16(input logic signed [31:0] v);
        return (v[31:15] == {17{v[15]}});
    endfunction

    // Stage p0: combinational encode and legality check against the current pc
    assign pc_plus4 = pc + 32'd4;
    assign br_diff  = $signed(target_i) - $signed(pc_plus4);
    assign br_off   = br_diff >>> 2;

    always_comb begin
        instr_p0 = '0;
        legal_p0 = 1'b0;
        case (kind_i)
            3'd0: begin
                instr_p0 = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
                legal_p0 = 1'b1;
            end
            3'd1: begin
                instr_p0 = {6'b001101, rs_i, rt_i, imm_i};
                legal_p0 = 1'b1;
            end
            3'd2: begin
                instr_p0 = {6'b100011, rs_i, rt_i, imm_i};
                legal_p0 = 1'b1;
            end
            3'd3: begin
                instr_p0 = {6'b101011, rs_i, rt_i, imm_i};
                legal_p0 = 1'b1;
            end
            3'd4: begin
                instr_p0 = {6'b000100, rs_i, rt_i, br_off[15:0]};
                legal_p0 = (target_i[1:0] == 2'b00) && fits_s16(br_off);
            end
            3'd5: begin
                instr_p0 = {6'b000010, target_i[27:2]};
                legal_p0 = (target_i[1:0] == 2'b00) &&
                           (target_i[31:28] == pc_plus4[31:28]);
            end
            default: begin
                instr_p0 = '0;
                legal_p0 = 1'b0;
            end
        endcase
    end

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && legal_p0) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    // Stage p1: registered write port, held between writes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc          <= '0;
            count       <= '0;
            mem_addr_p1 <= '0;
            mem_data_p1 <= '0;
        end else if (accept && legal_p0) begin
            pc          <= pc_plus4;
            count       <= sat_inc16(count);
            mem_addr_p1 <= pc;
            mem_data_p1 <= instr_p0;
        end
    end

    // A fresh error wins over a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                 err <= 1'b0;
        else if (accept && !legal_p0) err <= 1'b1;
        else if (err_clr_i)           err <= 1'b0;
    end

    assign mem_we_o   = (state == WRITE);
    assign mem_addr_o = mem_addr_p1;
    assign mem_data_o = mem_data_p1;
    assign pc_o       = pc;
    assign count_o    = count;
    assign err_o      = err;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps followed by randomized requests
// checked against an arithmetic reference of the encoding rules.
module tb_instr_encoder;

    localparam longint TWO31 = 64'sd2147483648;
    localparam longint TWO32 = 64'sd4294967296;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] target;
    logic        err_clr;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] pc;
    logic [15:0] count;
    logic        err;

    int total = 0;
    int bad   = 0;

    // reference state
    logic [31:0] m_pc;
    logic [15:0] m_count;
    logic        m_err;
    logic        m_busy;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    instr_encoder dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .kind_i      (kind),
        .rs_i        (rs),
        .rt_i        (rt),
        .rd_i        (rd),
        .funct_i     (funct),
        .imm_i       (imm),
        .target_i    (target),
        .err_clr_i   (err_clr),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .pc_o        (pc),
        .count_o     (count),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {legal, word} computed from the encoding rules with plain integer arithmetic
    function automatic logic [32:0] ref_encode(input longint k, input longint r_s,
                                               input longint r_t, input longint r_d,
                                               input longint fn, input longint im,
                                               input logic [31:0] tgt,
                                               input logic [31:0] pc_at);
        longint p4;
        longint t;
        longint diff;
        longint w;
        logic   ok;
        p4 = (longint'(pc_at) + 4) % TWO32;
        t  = longint'(tgt);
        ok = 1'b0;
        w  = 0;
        case (k)
            0: begin ok = 1'b1; w = (r_s << 21) + (r_t << 16) + (r_d << 11) + fn; end
            1: begin ok = 1'b1; w = (64'd13 << 26) + (r_s << 21) + (r_t << 16) + im; end
            2: begin ok = 1'b1; w = (64'd35 << 26) + (r_s << 21) + (r_t << 16) + im; end
            3: begin ok = 1'b1; w = (64'd43 << 26) + (r_s << 21) + (r_t << 16) + im; end
            4: begin
                diff = t - p4;
                if (diff >= TWO31) diff = diff - TWO32;
                else if (diff < -TWO31) diff = diff + TWO32;
                ok = (t % 4 == 0) && (diff >= -131072) && (diff <= 131068);
                w  = (64'd4 << 26) + (r_s << 21) + (r_t << 16) + ((diff / 4) & 65535);
            end
            5: begin
                ok = (t % 4 == 0) && ((t >> 28) == (p4 >> 28));
                w  = (64'd2 << 26) + ((t % (64'd1 << 28)) / 4);
            end
            default: ok = 1'b0;
        endcase
        return {ok, w[31:0]};
    endfunction

    task automatic set_req(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [5:0] f, input logic [15:0] i,
                           input logic [31:0] t);
        kind = k; rs = a; rt = b; rd = c; funct = f; imm = i; target = t;
    endtask

    task automatic gen_req();
        int          d;
        logic [31:0] r;
        logic [31:0] base;
        base = m_pc + 32'd4;
        r    = $urandom();
        kind = 3'($urandom_range(0, 7));
        rs = 5'($urandom()); rt = 5'($urandom()); rd = 5'($urandom());
        funct = 6'($urandom()); imm = 16'($urandom());
        case ($urandom_range(0, 3))
            0: begin d = int'($urandom_range(0, 65535)) - 32768; target = base + 32'(d * 4); end
            1: begin d = int'($urandom_range(0, 4095)) - 2048;   target = base + 32'(d * 64); end
            2: target = (base & 32'hF000_0000) | (r & 32'h0FFF_FFFF);
            default: target = r;
        endcase
    endtask

    initial begin
        logic [32:0] r;
        logic        exp_ready;
        logic        fired;
        logic        bad_acc;

        rst_n = 1'b0; req_valid = 1'b0; err_clr = 1'b0;
        set_req(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'd0);

        // reset values, held across a clock edge while reset is low
        #7;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_addr",  mem_addr,       32'd0);
        chk("rst_data",  mem_data,       32'd0);
        chk("rst_pc",    pc,             32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_err",   32'(err),       32'd0);

        @(negedge clk); rst_n = 1'b1;

        // R-type
        set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 32'd0); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("rtype_we",    32'(mem_we),    32'd1);
        chk("rtype_ready", 32'(req_ready), 32'd0);
        chk("rtype_addr",  mem_addr,       32'h0);
        chk("rtype_data",  mem_data,       32'h0022_1820);
        chk("rtype_pc",    pc,             32'h4);
        chk("rtype_count", 32'(count),     32'd1);
        @(posedge clk); #1;
        chk("idle_we",   32'(mem_we), 32'd0);
        chk("hold_data", mem_data,    32'h0022_1820);

        // ori
        set_req(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h00FF, 32'd0); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("ori_addr", mem_addr, 32'h4);
        chk("ori_data", mem_data, 32'h3408_00FF);
        chk("ori_pc",   pc,       32'h8);
        @(posedge clk); #1;

        // beq backwards at pc 0x8
        set_req(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'd0, 32'h4); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("beq_we",   32'(mem_we), 32'd1);
        chk("beq_addr", mem_addr,    32'h8);
        chk("beq_data", mem_data,    32'h1022_FFFE);
        @(posedge clk); #1;

        // j at pc 0xC
        set_req(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h40); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("j_addr",  mem_addr,   32'hC);
        chk("j_data",  mem_data,   32'h0800_0010);
        chk("j_pc",    pc,         32'h10);
        chk("j_count", 32'(count), 32'd4);
        @(posedge clk); #1;

        // misaligned beq: consumed, no write, sticky error
        set_req(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'd0, 32'h6); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("ill_we",    32'(mem_we),    32'd0);
        chk("ill_err",   32'(err),       32'd1);
        chk("ill_pc",    pc,             32'h10);
        chk("ill_count", 32'(count),     32'd4);
        chk("ill_ready", 32'(req_ready), 32'd1);
        chk("ill_data",  mem_data,       32'h0800_0010);
        @(posedge clk); #1;
        chk("err_sticky", 32'(err), 32'd1);

        err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        chk("clr_err", 32'(err), 32'd0);

        set_req(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h2); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("reerr", 32'(err), 32'd1);

        // clear together with an illegal kind: error wins
        set_req(3'd7, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 32'd0); req_valid = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0; err_clr = 1'b0;
        chk("clrset_err", 32'(err),    32'd1);
        chk("clrset_we",  32'(mem_we), 32'd0);
        chk("clrset_pc",  pc,          32'h10);

        // reset in the middle of a write cycle
        set_req(3'd0, 5'd5, 5'd6, 5'd7, 6'h2A, 16'd0, 32'd0); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        #2; rst_n = 1'b0; #1;
        chk("mrst_we",    32'(mem_we),    32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd1);
        chk("mrst_pc",    pc,             32'd0);
        chk("mrst_count", 32'(count),     32'd0);
        chk("mrst_err",   32'(err),       32'd0);
        chk("mrst_addr",  mem_addr,       32'd0);
        chk("mrst_data",  mem_data,       32'd0);

        // first edge after reset release accepts
        @(negedge clk); rst_n = 1'b1;
        set_req(3'd1, 5'd3, 5'd4, 5'd0, 6'd0, 16'h1234, 32'd0); req_valid = 1'b1;
        r = ref_encode(1, 3, 4, 0, 0, 16'h1234, 32'h0, 32'h0);
        @(posedge clk); #1; req_valid = 1'b0;
        chk("post_rst_we",    32'(mem_we), 32'd1);
        chk("post_rst_addr",  mem_addr,    32'd0);
        chk("post_rst_data",  mem_data,    r[31:0]);
        chk("post_rst_pc",    pc,          32'h4);
        chk("post_rst_count", 32'(count),  32'd1);
        @(posedge clk); #1;

        m_pc = 32'h4; m_count = 16'd1; m_err = 1'b0; m_busy = 1'b0;
        m_addr = 32'd0; m_data = r[31:0];

        // randomized requests, valid mostly held high
        gen_req(); req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            exp_ready = !m_busy;
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            @(posedge clk); #1;
            fired   = req_valid && exp_ready;
            bad_acc = 1'b0;
            m_busy  = 1'b0;
            if (fired) begin
                r = ref_encode(longint'(kind), longint'(rs), longint'(rt), longint'(rd),
                               longint'(funct), longint'(imm), target, m_pc);
                if (r[32]) begin
                    m_addr  = m_pc;
                    m_data  = r[31:0];
                    m_pc    = m_pc + 32'd4;
                    m_count = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
                    m_busy  = 1'b1;
                end else begin
                    bad_acc = 1'b1;
                end
            end
            m_err = bad_acc ? 1'b1 : (err_clr ? 1'b0 : m_err);
            chk("rnd_we",    32'(mem_we), 32'(m_busy));
            chk("rnd_addr",  mem_addr,    m_addr);
            chk("rnd_data",  mem_data,    m_data);
            chk("rnd_pc",    pc,          m_pc);
            chk("rnd_count", 32'(count),  32'(m_count));
            chk("rnd_err",   32'(err),    32'(m_err));
            err_clr = ($urandom_range(0, 7) == 0);
            if (fired) gen_req();
            req_valid = ($urandom_range(0, 9) != 0);
        end
        req_valid = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
        if (!bad_acc) m_err = m_err;

        // pc wrap from the top of the address space
        @(negedge clk);
        force dut.pc = 32'hFFFF_FFFC;
        #1;
        release dut.pc;
        m_pc = 32'hFFFF_FFFC;
        set_req(3'd0, 5'd9, 5'd10, 5'd11, 6'h25, 16'd0, 32'd0); req_valid = 1'b1;
        r = ref_encode(0, 9, 10, 11, 6'h25, 0, 32'd0, m_pc);
        m_count = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("wrap_we",    32'(mem_we), 32'd1);
        chk("wrap_addr",  mem_addr,    32'hFFFF_FFFC);
        chk("wrap_data",  mem_data,    r[31:0]);
        chk("wrap_pc",    pc,          32'h0);
        chk("wrap_count", 32'(count),  32'(m_count));
        @(posedge clk); #1;

        // count saturation
        @(negedge clk);
        force dut.count = 16'hFFFF;
        #1;
        release dut.count;
        set_req(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0010, 32'd0); req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("sat_we",    32'(mem_we), 32'd1);
        chk("sat_count", 32'(count),  32'hFFFF);
        chk("sat_addr",  mem_addr,    32'h0);
        chk("sat_pc",    pc,          32'h4);
        @(posedge clk); #1;
        chk("sat_hold", 32'(count), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
